// File: rtl/qc_fixed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : qc_fixed_pkg                                                 |
// | Description : Shared fixed-point constants, LFSR polynomial, measurement   |
// |               FSM encoding and the LFSR step function for the single-qubit |
// |               datapath. Amplitudes are signed Q8.8.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package qc_fixed_pkg;

    localparam int          FP_W              = 16;
    localparam int          PROD_W            = 32;   // Q16.16 square
    localparam int          PROB_W            = 33;   // sum of four squares
    localparam logic [15:0] FP_ZERO           = 16'h0000;
    localparam logic [15:0] FP_ONE            = 16'h0100;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQ0  = 3'd1,
        ST_SQ1  = 3'd2,
        ST_SQ2  = 3'd3,
        ST_SQ3  = 3'd4,
        ST_THR  = 3'd5,
        ST_DEC  = 3'd6,
        ST_HOLD = 3'd7
    } qm_state_t;

    // Galois right-shift step: the bit shifted out selects whether the
    // tap mask is folded back in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qc_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qc_lfsr16                                                    |
// | Description : 16-bit Galois LFSR (taps 16'hB400). Loads the seed on reset  |
// |               (a zero seed is replaced by 16'hACE1) and steps once for     |
// |               every cycle that advance is high.                            |
// | Ports       : clk, reset (sync, active-high), advance, seed[15:0],         |
// |               state[15:0]                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module qc_lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);
    import qc_fixed_pkg::*;

    logic [15:0] r_state;
    logic [15:0] w_seed_eff;

    // An all-zero state would lock the register up forever.
    assign w_seed_eff = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= w_seed_eff;
        end else if (advance) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/qubit_measure.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qubit_measure                                                |
// | Description : Projective measurement of a Q8.8 single-qubit state. The     |
// |               four squared amplitude components are formed one per cycle   |
// |               on a single shared 16x16 signed multiplier, then the outcome |
// |               is drawn by scaling the total probability by an LFSR sample. |
// | Ports       : clk, reset (sync, active-high)                               |
// |               in_valid/in_ready, alpha_re/im, beta_re/im (Q8.8 in)         |
// |               out_valid/out_ready, meas_bit, out_alpha_re/im,              |
// |               out_beta_re/im (collapsed state), zero_norm_err              |
// | Option      : QMEAS_FORCE_EN adds force_en/force_val to override the       |
// |               drawn outcome.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module qubit_measure #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          FP_W      = 16          // only 16 is supported
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [FP_W-1:0] alpha_re,
    input  logic signed [FP_W-1:0] alpha_im,
    input  logic signed [FP_W-1:0] beta_re,
    input  logic signed [FP_W-1:0] beta_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   meas_bit,
    output logic [FP_W-1:0]        out_alpha_re,
    output logic [FP_W-1:0]        out_alpha_im,
    output logic [FP_W-1:0]        out_beta_re,
    output logic [FP_W-1:0]        out_beta_im,
    output logic                   zero_norm_err
`ifdef QMEAS_FORCE_EN
    ,
    input  logic                   force_en,
    input  logic                   force_val
`endif
);
    import qc_fixed_pkg::*;

    qm_state_t              r_state;
    qm_state_t              w_state_nxt;
    logic signed [FP_W-1:0] r_ar, r_ai, r_br, r_bi;
    logic signed [FP_W-1:0] w_mul_op;
    logic signed [PROD_W-1:0] w_sq;
    logic [PROD_W-1:0]      r_p0, r_p1;
    logic [PROB_W-1:0]      w_total;
    logic [PROB_W-1:0]      r_thr;
    logic [PROB_W+15:0]     w_thr_prod;
    logic [15:0]            w_lfsr;
    logic                   w_advance;
    logic                   w_zero;
    logic                   w_lfsr_bit;
    logic                   w_bit;
    logic                   r_out_valid;
    logic                   r_meas_bit;
    logic                   r_err;
    logic [FP_W-1:0]        r_out_are;
    logic [FP_W-1:0]        r_out_bre;

    // The random source only moves on a decision, so a given seed replays
    // the same outcome sequence.
    assign w_advance = (r_state == ST_DEC);

    qc_lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_advance),
        .seed    (LFSR_SEED),
        .state   (w_lfsr)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_SQ0;
            ST_SQ0:  w_state_nxt = ST_SQ1;
            ST_SQ1:  w_state_nxt = ST_SQ2;
            ST_SQ2:  w_state_nxt = ST_SQ3;
            ST_SQ3:  w_state_nxt = ST_THR;
            ST_THR:  w_state_nxt = ST_DEC;
            ST_DEC:  w_state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready = (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Shared squarer: operand chosen by the current SQ state
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_op = '0;
        case (r_state)
            ST_SQ0:  w_mul_op = r_ar;
            ST_SQ1:  w_mul_op = r_ai;
            ST_SQ2:  w_mul_op = r_br;
            ST_SQ3:  w_mul_op = r_bi;
            default: w_mul_op = '0;
        endcase
    end

    // A square of -128.0 is exactly 2^30, so the signed 32-bit product is
    // always non-negative and two of them fit an unsigned 32-bit sum.
    assign w_sq    = w_mul_op * w_mul_op;
    assign w_total = {1'b0, r_p0} + {1'b0, r_p1};

    // total * lfsr / 65536 is strictly less than total, so a pure |0>
    // (p0 == total) can never reach the threshold.
    assign w_thr_prod = {16'h0000, w_total} * {{PROB_W{1'b0}}, w_lfsr};

    assign w_zero     = (w_total == '0);
    assign w_lfsr_bit = (r_thr >= {1'b0, r_p0}) && !w_zero;

`ifdef QMEAS_FORCE_EN
    assign w_bit = force_en ? force_val : w_lfsr_bit;
`else
    assign w_bit = w_lfsr_bit;
`endif

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar        <= '0;
            r_ai        <= '0;
            r_br        <= '0;
            r_bi        <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_thr       <= '0;
            r_out_valid <= 1'b0;
            r_meas_bit  <= 1'b0;
            r_err       <= 1'b0;
            r_out_are   <= FP_ZERO;
            r_out_bre   <= FP_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_ar <= alpha_re;
                        r_ai <= alpha_im;
                        r_br <= beta_re;
                        r_bi <= beta_im;
                    end
                end
                ST_SQ0:  r_p0 <= $unsigned(w_sq);
                ST_SQ1:  r_p0 <= r_p0 + $unsigned(w_sq);
                ST_SQ2:  r_p1 <= $unsigned(w_sq);
                ST_SQ3:  r_p1 <= r_p1 + $unsigned(w_sq);
                ST_THR:  r_thr <= PROB_W'(w_thr_prod >> 16);
                ST_DEC: begin
                    r_out_valid <= 1'b1;
                    r_meas_bit  <= w_bit;
                    r_err       <= w_zero;
                    r_out_are   <= w_bit ? FP_ZERO : FP_ONE;
                    r_out_bre   <= w_bit ? FP_ONE  : FP_ZERO;
                end
                ST_HOLD: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Collapse always lands on a real basis vector; imaginary parts are zero.
    assign out_valid     = r_out_valid;
    assign meas_bit      = r_meas_bit;
    assign zero_norm_err = r_err;
    assign out_alpha_re  = r_out_are;
    assign out_alpha_im  = FP_ZERO;
    assign out_beta_re   = r_out_bre;
    assign out_beta_im   = FP_ZERO;

endmodule
`default_nettype wire

// File: tb/tb_qubit_measure.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_qubit_measure                                             |
// | Description : Scoreboard bench for qubit_measure. The driver predicts each |
// |               outcome from the probability rules when a state is accepted  |
// |               and queues it; a monitor pops and compares whenever a result |
// |               is presented and while it is held.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_qubit_measure;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        meas_bit, zero_norm_err;
    logic [15:0] alpha_re, alpha_im, beta_re, beta_im;
    logic [15:0] out_alpha_re, out_alpha_im, out_beta_re, out_beta_im;
    logic        force_en, force_val;

    always #5 clk = ~clk;

    qubit_measure #(.LFSR_SEED(SEED), .FP_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alpha_re      (alpha_re),
        .alpha_im      (alpha_im),
        .beta_re       (beta_re),
        .beta_im       (beta_im),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .meas_bit      (meas_bit),
        .out_alpha_re  (out_alpha_re),
        .out_alpha_im  (out_alpha_im),
        .out_beta_re   (out_beta_re),
        .out_beta_im   (out_beta_im),
        .zero_norm_err (zero_norm_err)
`ifdef QMEAS_FORCE_EN
        ,
        .force_en      (force_en),
        .force_val     (force_val)
`endif
    );

    typedef struct {
        logic bit_v;
        logic err;
        int   acc_edge;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic        have_cur = 1'b0;
    logic        prev_valid = 1'b0;
    logic        rand_ready = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          handshakes = 0;
    int          presented = 0;
    int          ones = 0;
    int          model_ones = 0;
    logic [15:0] lfsr_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, straight from the probability rules.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [1:0] predict(input logic [15:0] ar, input logic [15:0] ai,
                                           input logic [15:0] br, input logic [15:0] bi,
                                           input logic [15:0] l,
                                           input logic fe, input logic fv);
        longint a, b, c, d, p0, p1, total, thr;
        logic   err, bv;
        a = longint'($signed(ar));
        b = longint'($signed(ai));
        c = longint'($signed(br));
        d = longint'($signed(bi));
        p0    = a * a + b * b;
        p1    = c * c + d * d;
        total = p0 + p1;
        thr   = (total * longint'(l)) / 65536;
        err   = (total == 0);
        bv    = err ? 1'b0 : (thr >= p0);
        if (fe) bv = fv;
        return {err, bv};
    endfunction

    // Driver: called at a negedge; waits for in_ready, presents one state,
    // queues its predicted outcome.
    task automatic send(input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi);
        int         guard = 0;
        exp_t       e;
        logic [1:0] pr;
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
                return;
            end
        end
        alpha_re = ar; alpha_im = ai; beta_re = br; beta_im = bi;
        in_valid = 1'b1;
        pr = predict(ar, ai, br, bi, lfsr_m, force_en, force_val);
        e.bit_v    = pr[0];
        e.err      = pr[1];
        e.acc_edge = cyc + 1;
        q.push_back(e);
        model_ones += int'(pr[0]);
        lfsr_m = lfsr_step(lfsr_m);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || out_valid) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: queue=%0d out_valid=%0b, required 0/0", q.size(), out_valid);
        end
    endtask

    // Monitor: compares on presentation and keeps comparing while held.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !prev_valid) begin
                presented++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_output: out_valid=1 with no pending state, required 0");
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    ones += int'(meas_bit);
                    check("latency", 64'(cyc - cur.acc_edge), 64'd6);
                end
            end
            if (out_valid && have_cur) begin
                check("meas_bit",      meas_bit,      cur.bit_v);
                check("zero_norm_err", zero_norm_err, cur.err);
                check("out_alpha_re",  out_alpha_re,  cur.bit_v ? 16'h0000 : 16'h0100);
                check("out_alpha_im",  out_alpha_im,  16'h0000);
                check("out_beta_re",   out_beta_re,   cur.bit_v ? 16'h0100 : 16'h0000);
                check("out_beta_im",   out_beta_im,   16'h0000);
                check("in_ready_busy", in_ready,      1'b0);
            end
            if (out_valid && out_ready) handshakes++;
        end
        prev_valid <= out_valid;
    end

    always @(negedge clk) begin
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        logic [15:0] v[4];
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alpha_re  = '0; alpha_im = '0; beta_re = '0; beta_im = '0;
        force_en  = 1'b0;
        force_val = 1'b0;
        lfsr_m    = SEED;

        repeat (3) @(negedge clk);
        check("rst_in_ready",     in_ready,      1'b1);
        check("rst_out_valid",    out_valid,     1'b0);
        check("rst_meas_bit",     meas_bit,      1'b0);
        check("rst_out_alpha_re", out_alpha_re,  16'h0000);
        check("rst_out_beta_re",  out_beta_re,   16'h0000);
        check("rst_err",          zero_norm_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Directed basis states and boundaries
        send(16'h0100, 16'h0000, 16'h0000, 16'h0000); drain();
        send(16'h0000, 16'h0000, 16'h0100, 16'h0000); drain();
        send(16'h0000, 16'h0000, 16'h0000, 16'h0000); drain();
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000); drain();
        send(16'h8000, 16'h8000, 16'h0000, 16'h0000); drain();
        send(16'h0000, 16'h0000, 16'h8000, 16'h8000); drain();

        // Random states with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++)
                v[k] = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
            send(v[0], v[1], v[2], v[3]);
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        @(negedge clk);

        // Held result: stable outputs, second request ignored
        out_ready = 1'b0;
        send(16'h00B5, 16'h0000, 16'h00B5, 16'h0000);
        for (int g = 0; g < 50 && !out_valid; g++) @(negedge clk);
        check("hold_reached", out_valid, 1'b1);
        alpha_re = 16'h0000; beta_re = 16'h0100; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid, 1'b0);
        check("release_in_ready",  in_ready,  1'b1);
        repeat (10) @(negedge clk);
        check("no_extra_result", out_valid, 1'b0);
        check("handshakes_hold", 64'(handshakes), 64'(presented));

        // Reset during SQ2 aborts and reloads the LFSR
        send(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        lfsr_m = SEED;
        check("abort_in_ready",  in_ready,  1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        repeat (8) @(negedge clk);
        check("abort_no_result", out_valid, 1'b0);

        // 1000 equal-superposition shots from a fresh seed
        ones = 0; model_ones = 0;
        for (int i = 0; i < 1000; i++) send(16'h00B5, 16'h0000, 16'h00B5, 16'h0000);
        drain();
        check("ones_in_range", 64'((ones >= 400) && (ones <= 600)), 64'd1);
        check("ones_vs_model", 64'(ones), 64'(model_ones));

        // Same seed again: the model restarts from the seed too
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lfsr_m = SEED;
        ones = 0; model_ones = 0;
        for (int i = 0; i < 200; i++) send(16'h00B5, 16'h0000, 16'h00B5, 16'h0000);
        drain();
        check("rerun_ones_vs_model", 64'(ones), 64'(model_ones));

`ifdef QMEAS_FORCE_EN
        force_en = 1'b1; force_val = 1'b1;
        send(16'h0100, 16'h0000, 16'h0000, 16'h0000); drain();
        force_val = 1'b0;
        send(16'h0000, 16'h0000, 16'h0100, 16'h0000); drain();
        force_en = 1'b0;
`endif

        check("queue_empty",     64'(q.size()),   64'd0);
        check("handshake_count", 64'(handshakes), 64'(presented));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
